// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared types and constants for the 4x4 keypad digit-entry block:
//            FSM state and scan-result encodings, key index constants and the
//            key-index-to-function table.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Debounce FSM state encoding
    typedef logic [1:0] kp_state_t;
    localparam kp_state_t c_ST_IDLE     = 2'd0;
    localparam kp_state_t c_ST_DEBOUNCE = 2'd1;
    localparam kp_state_t c_ST_PRESSED  = 2'd2;

    // Classification of one complete 16-key scan
    typedef logic [1:0] kp_result_t;
    localparam kp_result_t c_RES_NONE   = 2'd0;
    localparam kp_result_t c_RES_SINGLE = 2'd1;
    localparam kp_result_t c_RES_MULTI  = 2'd2;

    // Key index = row*4 + col
    localparam logic [3:0] c_KEY_A    = 4'd3;
    localparam logic [3:0] c_KEY_B    = 4'd7;
    localparam logic [3:0] c_KEY_C    = 4'd11;
    localparam logic [3:0] c_KEY_STAR = 4'd12;
    localparam logic [3:0] c_KEY_HASH = 4'd14;
    localparam logic [3:0] c_KEY_D    = 4'd15;

    // Function of each key, nibble i = key index i.
    // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D  (A-D = 4'hA-4'hD, *=E, #=F)
    localparam logic [63:0] c_KEY_TABLE = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_func(input logic [3:0] idx);
        return c_KEY_TABLE[{idx, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Brief    : Column scanner for a 4x4 active-low keypad. Synchronizes ROW,
//            rotates the column drive every SCAN_DIV cycles, latches the rows
//            per column and classifies each complete scan.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic       o_scan_done,
    output kp_result_t o_result,
    output logic [3:0] o_key_index
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_col_idx;
    logic [15:0]        r_latch;     // bit row*4+col, low = key closed
    logic               r_scan_done;
    logic               w_div_tc;
    logic               w_any_low;
    logic               w_multi_low;
    logic [3:0]         w_low_index;

    assign w_div_tc    = (r_div == c_DIV_W'(SCAN_DIV - 1));
    assign o_col       = ~(4'b0001 << r_col_idx);
    assign o_scan_done = r_scan_done;
    assign o_key_index = w_low_index;

    // Two-flop synchronizer for the asynchronous row inputs (idle = all high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= i_row;
            r_row_sync <= r_row_meta;
        end
    end

    // Divider, row latch for the driven column, column rotation and scan_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div       <= '0;
            r_col_idx   <= 2'd0;
            r_latch     <= '1;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (w_div_tc) begin
                r_div <= '0;
                for (int r = 0; r < 4; r++) begin
                    r_latch[{2'(r), r_col_idx}] <= r_row_sync[r];
                end
                r_col_idx   <= r_col_idx + 2'd1;
                r_scan_done <= (r_col_idx == 2'd3);
            end else begin
                r_div <= r_div + c_DIV_W'(1);
            end
        end
    end

    // Count low bits (none / one / several) and locate the low bit
    always_comb begin
        w_any_low   = 1'b0;
        w_multi_low = 1'b0;
        w_low_index = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (!r_latch[i]) begin
                if (w_any_low) begin
                    w_multi_low = 1'b1;
                end
                w_any_low   = 1'b1;
                w_low_index = 4'(i);
            end
        end
        if (w_multi_low) begin
            o_result = c_RES_MULTI;
        end else if (w_any_low) begin
            o_result = c_RES_SINGLE;
        end else begin
            o_result = c_RES_NONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_digit_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_digit_entry
// Brief    : Debounced 4x4 keypad front end producing digit, clear and enter
//            strobes for the barcode shift-register interface, plus a count
//            of digits entered since the last clear or enter.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_digit_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int MAX_DIGITS     = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] Digit_out,
    output logic       DigitStrobe,
    output logic       ClearStrobe,
    output logic       EnterStrobe,
    output logic [2:0] DigitCount,
    output logic       KeyHeld
);

    localparam int               c_CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_CNT_W-1:0] c_DS  = c_CNT_W'(DEBOUNCE_SCANS);
    localparam logic [2:0]       c_MAX   = 3'(MAX_DIGITS);

    logic               w_scan_done;
    kp_result_t         w_result;
    logic [3:0]         w_key_index;

    kp_state_t          r_state,  w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [3:0]         r_cand,   w_cand_nxt;
    logic               w_accept;

    logic [3:0]         r_digit,  w_digit_nxt;
    logic               r_dstb,   w_dstb_nxt;
    logic               r_cstb,   w_cstb_nxt;
    logic               r_estb,   w_estb_nxt;
    logic [2:0]         r_count,  w_count_nxt;
    logic [3:0]         w_func;
    logic               w_is_digit;

    keypad_scan #(
        .SCAN_DIV    (SCAN_DIV)
    ) u_scan (
        .clk         (CLK),
        .rst         (RESET),
        .i_row       (ROW),
        .o_col       (COL),
        .o_scan_done (w_scan_done),
        .o_result    (w_result),
        .o_key_index (w_key_index)
    );

    assign Digit_out   = r_digit;
    assign DigitStrobe = r_dstb;
    assign ClearStrobe = r_cstb;
    assign EnterStrobe = r_estb;
    assign DigitCount  = r_count;
    assign KeyHeld     = (r_state == c_ST_PRESSED);

    assign w_func     = key_func(r_cand);
    assign w_is_digit = !(r_cand inside {c_KEY_A, c_KEY_B, c_KEY_C, c_KEY_D,
                                         c_KEY_STAR, c_KEY_HASH});

    // State register: FSM state, debounce counter, candidate key and outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
            r_digit <= 4'hF;
            r_dstb  <= 1'b0;
            r_cstb  <= 1'b0;
            r_estb  <= 1'b0;
            r_count <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
            r_digit <= w_digit_nxt;
            r_dstb  <= w_dstb_nxt;
            r_cstb  <= w_cstb_nxt;
            r_estb  <= w_estb_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next state: debounce press then release, stepping only on scan_done
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        if (w_scan_done) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_result == c_RES_SINGLE) begin
                        w_cand_nxt  = w_key_index;
                        w_cnt_nxt   = c_CNT_W'(1);
                        w_state_nxt = c_ST_DEBOUNCE;
                    end
                end
                c_ST_DEBOUNCE: begin
                    if ((w_result == c_RES_SINGLE) && (w_key_index == r_cand)) begin
                        if (r_cnt + c_CNT_W'(1) == c_DS) begin
                            w_accept    = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_ST_PRESSED;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                c_ST_PRESSED: begin
                    // Any key activity restarts the release count; no repeat
                    if (w_result == c_RES_NONE) begin
                        if (r_cnt + c_CNT_W'(1) == c_DS) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_ST_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs: decode the accepted key into at most one strobe
    always_comb begin
        w_digit_nxt = r_digit;
        w_count_nxt = r_count;
        w_dstb_nxt  = 1'b0;
        w_cstb_nxt  = 1'b0;
        w_estb_nxt  = 1'b0;
        if (w_accept) begin
            if (w_is_digit) begin
                if (r_count < c_MAX) begin
                    w_digit_nxt = w_func;
                    w_dstb_nxt  = 1'b1;
                    w_count_nxt = r_count + 3'd1;
                end
            end else if (r_cand == c_KEY_STAR) begin
                w_cstb_nxt  = 1'b1;
                w_count_nxt = 3'd0;
            end else if ((r_cand == c_KEY_HASH) && (r_count == c_MAX)) begin
                w_estb_nxt  = 1'b1;
                w_count_nxt = 3'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_digit_entry
// Brief    : Directed self-checking bench for keypad_digit_entry with a
//            behavioural 4x4 switch-matrix model on ROW/COL.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_digit_entry;

    localparam int c_SCAN_DIV = 4;
    localparam int c_DS       = 3;
    localparam int c_MAX      = 4;
    localparam int c_SCAN     = 4 * c_SCAN_DIV;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] Digit_out;
    logic       DigitStrobe;
    logic       ClearStrobe;
    logic       EnterStrobe;
    logic [2:0] DigitCount;
    logic       KeyHeld;

    logic [15:0] keys = 16'h0000;   // bit row*4+col = switch closed
    int          n_vec = 0;
    int          n_err = 0;
    int          n_dig = 0;
    int          n_clr = 0;
    int          n_ent = 0;
    int          n_multi = 0;
    logic [3:0]  last_digit = 4'hF;

    keypad_digit_entry #(
        .SCAN_DIV       (c_SCAN_DIV),
        .DEBOUNCE_SCANS (c_DS),
        .MAX_DIGITS     (c_MAX)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ROW         (ROW),
        .COL         (COL),
        .Digit_out   (Digit_out),
        .DigitStrobe (DigitStrobe),
        .ClearStrobe (ClearStrobe),
        .EnterStrobe (EnterStrobe),
        .DigitCount  (DigitCount),
        .KeyHeld     (KeyHeld)
    );

    always #5 CLK = ~CLK;

    // Switch matrix: a row reads low when a closed switch sits on a low column
    always_comb begin
        ROW = 4'hF;
        for (int r = 0; r < 4; r++) begin
            ROW[r] = ~|(keys[r*4 +: 4] & ~COL);
        end
    end

    // Strobe tally, sampled mid-cycle
    always @(negedge CLK) begin
        if (DigitStrobe) begin
            n_dig++;
            last_digit = Digit_out;
        end
        if (ClearStrobe) n_clr++;
        if (EnterStrobe) n_ent++;
        if ((32'(DigitStrobe) + 32'(ClearStrobe) + 32'(EnterStrobe)) > 1) n_multi++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * c_SCAN) @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic press_key(input int idx);
        keys = 16'h0001 << idx;
        wait_scans(5);
        keys = 16'h0000;
        wait_scans(4);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_col"},   32'(COL), 32'hE);
        check_eq({tag, "_digit"}, 32'(Digit_out), 32'hF);
        check_eq({tag, "_count"}, 32'(DigitCount), 32'd0);
        check_eq({tag, "_flags"}, 32'({DigitStrobe, ClearStrobe, EnterStrobe, KeyHeld}), 32'd0);
    endtask

    int         entry_idx [4] = '{0, 1, 2, 4};
    logic [3:0] entry_val [4] = '{4'd1, 4'd2, 4'd3, 4'd4};

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;
        check_reset_values("reset");
        RESET = 1'b0;

        // T1: hold '5' then release
        keys = 16'h0001 << 5;
        wait_scans(5);
        check_eq("t1_held",   32'(KeyHeld), 32'd1);
        check_eq("t1_nstb",   n_dig, 1);
        check_eq("t1_digit",  32'(last_digit), 32'd5);
        check_eq("t1_count",  32'(DigitCount), 32'd1);
        keys = 16'h0000;
        wait_scans(4);
        check_eq("t1_release", 32'(KeyHeld), 32'd0);
        check_eq("t1_norepeat", n_dig, 1);

        // T2: bouncing '7', then stable
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? (16'h0001 << 8) : 16'h0000;
            wait_scans(1);
        end
        check_eq("t2_bounce", n_dig, 1);
        keys = 16'h0001 << 8;
        wait_scans(2);
        check_eq("t2_early", n_dig, 1);
        wait_scans(1);
        keys = 16'h0000;
        wait_scans(4);
        check_eq("t2_nstb",  n_dig, 2);
        check_eq("t2_digit", 32'(last_digit), 32'd7);
        check_eq("t2_count", 32'(DigitCount), 32'd2);

        // T4: '#' with two digits is ignored, '*' clears
        press_key(14);
        check_eq("t4_hash_ign", n_ent, 0);
        check_eq("t4_hash_cnt", 32'(DigitCount), 32'd2);
        press_key(12);
        check_eq("t4_clr",       n_clr, 1);
        check_eq("t4_clr_cnt",   32'(DigitCount), 32'd0);
        check_eq("t4_clr_digit", 32'(Digit_out), 32'd7);

        // T3: 1,2,3,4 accepted, 9 ignored at the limit, then '#'
        for (int i = 0; i < 4; i++) begin
            press_key(entry_idx[i]);
            check_eq("t3_digit", 32'(Digit_out), 32'(entry_val[i]));
            check_eq("t3_count", 32'(DigitCount), 32'(i + 1));
        end
        press_key(10);
        check_eq("t3_9_nstb",  n_dig, 6);
        check_eq("t3_9_digit", 32'(Digit_out), 32'd4);
        check_eq("t3_9_count", 32'(DigitCount), 32'd4);
        press_key(14);
        check_eq("t3_enter",     n_ent, 1);
        check_eq("t3_enter_cnt", 32'(DigitCount), 32'd0);

        // T5: '1'+'2' together (MULTI), then only '1'
        keys = 16'h0003;
        wait_scans(5);
        check_eq("t5_multi_nstb", n_dig, 6);
        check_eq("t5_multi_held", 32'(KeyHeld), 32'd0);
        keys = 16'h0001;
        wait_scans(2);
        check_eq("t5_early", n_dig, 6);
        wait_scans(3);
        check_eq("t5_nstb",  n_dig, 7);
        check_eq("t5_digit", 32'(Digit_out), 32'd1);
        check_eq("t5_count", 32'(DigitCount), 32'd1);
        keys = 16'h0000;
        wait_scans(4);

        // T6: reset during debounce of '8'
        keys = 16'h0001 << 9;
        wait_scans(2);
        check_eq("t6_predeb", n_dig, 7);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_values("t6_async");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        wait_scans(5);
        check_eq("t6_nstb",  n_dig, 8);
        check_eq("t6_digit", 32'(Digit_out), 32'd8);
        check_eq("t6_count", 32'(DigitCount), 32'd1);
        keys = 16'h0000;
        wait_scans(4);

        check_eq("onehot_strobes", n_multi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
